i2s_clock_gen: RTL and testbench
================================

I2S_CLOCK_GEN -- requirements
Module: i2s_clock_gen

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 17, clk_in cycles per sck half-period (legal range 1 and above).
REQ-002 SHALL have parameter BITS_PER_SLOT, default 32, sck periods per slot (legal range 2 and above).
REQ-003 SHALL have parameter NUM_SLOTS, default 2, slots per frame (1 or more in MODE 2; even, 2 or more, in MODES 0/1).
REQ-004 SHALL have parameter MODE, default 0: 0 = I2S (ws leads by one bit), 1 = left-justified, 2 = TDM short frame-sync pulse.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock. Reset is synchronous and active-high.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port enable_in, input, 1 bit: level request to run the bus.
REQ-008 SHALL have port sck, output, 1 bit: serial bit clock.
REQ-009 SHALL have port ws, output, 1 bit: word select or frame sync.
REQ-010 SHALL have port sck_rise_out, output, 1 bit: one-cycle strobe in the cycle sck becomes 1.
REQ-011 SHALL have port sck_fall_out, output, 1 bit: one-cycle strobe in the cycle sck becomes 0.
REQ-012 SHALL have port bit_idx_out, output, $clog2(BITS_PER_SLOT) bits: current bit within the slot (0 = MSB).
REQ-013 SHALL have port slot_idx_out, output, max(1,$clog2(NUM_SLOTS)) bits: current slot.
REQ-014 SHALL have port frame_start_out, output, 1 bit: one-cycle strobe when the counters become slot 0, bit 0.
REQ-015 SHALL have port running_out, output, 1 bit: high in states RUN and DRAIN.

Function
REQ-016 SHALL implement states IDLE, RUN and DRAIN with these transitions:
- IDLE to RUN when enable_in=1.
- RUN to DRAIN when enable_in=0.
- DRAIN to RUN when enable_in=1.
- DRAIN to IDLE at the frame-wrap falling edge; this transition takes priority over enable_in.
REQ-017 In IDLE, SHALL hold sck=0, ws=0, div counter=0, bit_idx=0 and slot_idx=0.
REQ-018 On the IDLE-to-RUN cycle, SHALL pulse frame_start_out.
REQ-019 In RUN and DRAIN, SHALL count the div counter 0..HALF_PERIOD-1; when it reaches HALF_PERIOD-1, sck SHALL toggle and the counter SHALL return to 0.
REQ-020 Consequently, the nth falling edge SHALL occur n*2*HALF_PERIOD cycles after RUN entry.
REQ-021 SHALL register sck_rise_out and sck_fall_out so they are coincident with the new sck value.
REQ-022 SHALL advance bit_idx on each sck falling edge; at BITS_PER_SLOT-1 it SHALL wrap to 0 and slot_idx SHALL increment.
REQ-023 slot_idx SHALL wrap to 0 after NUM_SLOTS-1; this wrap SHALL pulse frame_start_out.
REQ-024 Slot ws level for MODES 0/1 SHALL be 0 for slots below NUM_SLOTS/2, else 1.
REQ-025 In MODE 0, ws SHALL update at the falling edge where bit_idx becomes BITS_PER_SLOT-1, taking the level of the next slot (modulo NUM_SLOTS).
REQ-026 In MODE 1, ws SHALL update at the falling edge where bit_idx becomes 0, taking the level of the new slot.
REQ-027 In MODE 2, ws SHALL be 1 only for the sck period with slot 0, bit 0, and 0 otherwise, including IDLE.
REQ-028 When HALF_PERIOD=1, sck SHALL toggle every cycle and strobes SHALL alternate every cycle.
REQ-029 A DRAIN that reaches IDLE SHALL leave sck=0 and ws=0, with no partial frame ever emitted.

Reset
REQ-030 While rst_in=1, at every clk_in edge the state SHALL go to IDLE and all outputs and counters SHALL become 0, regardless of state or mid-frame position.
REQ-031 After rst_in falls, RUN SHALL start only when enable_in is sampled high.

Structure
REQ-032 Package i2s_pkg SHALL hold the mode constants (I2S_MODE_I2S=0, I2S_MODE_LJ=1, I2S_MODE_TDM=2) and the state enum (IDLE, RUN, DRAIN).
REQ-033 The sck divider and edge strobes SHALL live in one sub-module, i2s_sck_divider (parameter HALF_PERIOD; ports clk_in, rst_in, run_in, sck, rise_out, fall_out).
REQ-034 An elaboration-time check SHALL reject illegal parameter combinations.

Verification
REQ-035 Defaults, enable held high: sck period is 34 cycles; ws rises 1054 cycles after RUN entry; frame_start_out repeats every 2176 cycles.
REQ-036 MODE=1, defaults otherwise: ws rises 1088 cycles after RUN entry and falls 2176 cycles after it.
REQ-037 MODE=2, NUM_SLOTS=8, BITS_PER_SLOT=16, HALF_PERIOD=2: ws is high exactly 4 cycles per frame, frame period 512 cycles, and ws is aligned with frame_start_out.
REQ-038 Defaults, enable_in dropped at slot 0 bit 10: the frame completes, then running_out=0 with sck=0, ws=0 and indices 0.
REQ-039 Defaults, enable_in re-raised during DRAIN: sck and indices continue with no gap or restart.
REQ-040 Defaults, rst_in pulsed at slot 1 bit 5: the next cycle has all outputs 0 and state IDLE.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants, controller state encoding and helpers for the I2S/TDM clock generator.
package i2s_pkg;

  localparam int I2S_MODE_I2S = 0;
  localparam int I2S_MODE_LJ  = 1;
  localparam int I2S_MODE_TDM = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } i2s_state_t;

  // Word-select level for a slot: first half of the frame is the left/low channel.
  function automatic logic ws_level(input int slot, input int num_slots);
    return slot >= (num_slots / 2);
  endfunction

endpackage

// File: rtl/i2s_sck_divider.sv
// Serial bit-clock divider: toggles sck every HALF_PERIOD cycles while run_in is high,
// with one-cycle strobes coincident with the new sck level.
module i2s_sck_divider #(
  parameter int HALF_PERIOD = 17
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic run_in,
  output logic sck,
  output logic rise_out,
  output logic fall_out
);

  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

  logic [DW-1:0] div_q;

  // Dropping run_in parks the divider so the next run starts from a clean half-period.
  always_ff @(posedge clk_in) begin
    if (rst_in || !run_in) begin
      div_q    <= '0;
      sck      <= 1'b0;
      rise_out <= 1'b0;
      fall_out <= 1'b0;
    end else begin
      rise_out <= 1'b0;
      fall_out <= 1'b0;
      if (div_q == DIV_LAST) begin
        div_q    <= '0;
        sck      <= ~sck;
        rise_out <= ~sck;
        fall_out <= sck;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_clock_gen.sv
// I2S / left-justified / TDM bit clock and word-select generator whose
// IDLE/RUN/DRAIN controller only ever stops on a frame boundary.
module i2s_clock_gen
  import i2s_pkg::*;
#(
  parameter int HALF_PERIOD   = 17,
  parameter int BITS_PER_SLOT = 32,
  parameter int NUM_SLOTS     = 2,
  parameter int MODE          = I2S_MODE_I2S,
  localparam int BW = $clog2(BITS_PER_SLOT),
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          enable_in,
  output logic          sck,
  output logic          ws,
  output logic          sck_rise_out,
  output logic          sck_fall_out,
  output logic [BW-1:0] bit_idx_out,
  output logic [SW-1:0] slot_idx_out,
  output logic          frame_start_out,
  output logic          running_out
);

  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS_PER_SLOT - 1);
  localparam logic [BW-1:0] BIT_PENULT = BW'(BITS_PER_SLOT - 2);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_SLOTS - 1);

  if (HALF_PERIOD < 1 || BITS_PER_SLOT < 2 || NUM_SLOTS < 1 || MODE < 0 || MODE > 2 ||
      (MODE != I2S_MODE_TDM && (NUM_SLOTS < 2 || (NUM_SLOTS % 2) != 0))) begin : g_bad_params
    $error("i2s_clock_gen: illegal parameter combination");
  end

  i2s_state_t    state;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d, slot_inc;
  logic          ws_q, ws_d, start_q;
  logic          fall, last_bit, last_slot, wrap, stop, run_div;

  // Cutting run_in in the same cycle as the closing fall keeps sck parked low,
  // even when HALF_PERIOD=1 would otherwise raise it on the very next edge.
  assign run_div = (state != IDLE) && !stop;

  i2s_sck_divider #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .run_in  (run_div),
    .sck     (sck),
    .rise_out(sck_rise_out),
    .fall_out(fall)
  );

  assign last_bit  = (bit_q == BIT_LAST);
  assign last_slot = (slot_q == SLOT_LAST);
  assign slot_inc  = last_slot ? '0 : slot_q + 1'b1;
  assign wrap      = fall && last_bit && last_slot;
  assign stop      = wrap && (state == DRAIN);

  // Counters and ws advance in the same cycle sck falls; the registers catch up one cycle later.
  always_comb begin
    bit_d  = bit_q;
    slot_d = slot_q;
    ws_d   = ws_q;
    if (fall) begin
      bit_d = last_bit ? '0 : bit_q + 1'b1;
      if (last_bit) slot_d = slot_inc;
      case (MODE)
        I2S_MODE_I2S: if (bit_q == BIT_PENULT) ws_d = ws_level(int'(slot_inc), NUM_SLOTS);
        I2S_MODE_LJ:  if (last_bit) ws_d = ws_level(int'(slot_inc), NUM_SLOTS);
        default:      ws_d = wrap && !stop;
      endcase
    end
  end

  assign sck_fall_out    = fall;
  assign ws              = ws_d;
  assign bit_idx_out     = bit_d;
  assign slot_idx_out    = slot_d;
  assign frame_start_out = start_q || (wrap && !stop);
  assign running_out     = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      ws_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          bit_q  <= '0;
          slot_q <= '0;
          ws_q   <= 1'b0;
          if (enable_in) begin
            state   <= RUN;
            start_q <= 1'b1;
            ws_q    <= (MODE == I2S_MODE_TDM);
          end
        end
        RUN: begin
          bit_q  <= bit_d;
          slot_q <= slot_d;
          ws_q   <= ws_d;
          if (!enable_in) state <= DRAIN;
        end
        default: begin
          bit_q  <= bit_d;
          slot_q <= slot_d;
          ws_q   <= ws_d;
          if (stop) state <= IDLE;
          else if (enable_in) state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Self-checking bench for i2s_clock_gen: four parameterisations driven from one clock,
// with expected frame events queued up front and matched as the DUTs produce them.
module tb_i2s_clock_gen;

  logic clk_in = 1'b0;
  logic rst_in;
  logic en0, en1, en2, en3;

  logic       sck0, ws0, rise0, fall0, fs0, run0;
  logic [4:0] bit0;
  logic [0:0] slot0;
  logic       sck1, ws1, rise1, fall1, fs1, run1;
  logic [4:0] bit1;
  logic [0:0] slot1;
  logic       sck2, ws2, rise2, fall2, fs2, run2;
  logic [3:0] bit2;
  logic [2:0] slot2;
  logic       sck3, ws3, rise3, fall3, fs3, run3;
  logic [0:0] bit3;
  logic [0:0] slot3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  typedef struct {
    logic sck, ws, rise, fall, fs, run;
    int   bidx;
    int   sidx;
  } obs_t;

  localparam int EV_FS      = 0;
  localparam int EV_WS_RISE = 1;
  localparam int EV_WS_FALL = 2;

  ev_t  exp_q[$];
  obs_t exp_obs_q[$];

  always #5 clk_in = ~clk_in;

  i2s_clock_gen u_def (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(en0), .sck(sck0), .ws(ws0),
    .sck_rise_out(rise0), .sck_fall_out(fall0), .bit_idx_out(bit0), .slot_idx_out(slot0),
    .frame_start_out(fs0), .running_out(run0)
  );

  i2s_clock_gen #(.MODE(1)) u_lj (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(en1), .sck(sck1), .ws(ws1),
    .sck_rise_out(rise1), .sck_fall_out(fall1), .bit_idx_out(bit1), .slot_idx_out(slot1),
    .frame_start_out(fs1), .running_out(run1)
  );

  i2s_clock_gen #(.HALF_PERIOD(2), .BITS_PER_SLOT(16), .NUM_SLOTS(8), .MODE(2)) u_tdm (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(en2), .sck(sck2), .ws(ws2),
    .sck_rise_out(rise2), .sck_fall_out(fall2), .bit_idx_out(bit2), .slot_idx_out(slot2),
    .frame_start_out(fs2), .running_out(run2)
  );

  i2s_clock_gen #(.HALF_PERIOD(1), .BITS_PER_SLOT(2), .NUM_SLOTS(2), .MODE(0)) u_fast (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(en3), .sck(sck3), .ws(ws3),
    .sck_rise_out(rise3), .sck_fall_out(fall3), .bit_idx_out(bit3), .slot_idx_out(slot3),
    .frame_start_out(fs3), .running_out(run3)
  );

  function automatic obs_t sample(input int d);
    obs_t o;
    case (d)
      0:       o = '{sck0, ws0, rise0, fall0, fs0, run0, int'(bit0), int'(slot0)};
      1:       o = '{sck1, ws1, rise1, fall1, fs1, run1, int'(bit1), int'(slot1)};
      2:       o = '{sck2, ws2, rise2, fall2, fs2, run2, int'(bit2), int'(slot2)};
      default: o = '{sck3, ws3, rise3, fall3, fs3, run3, int'(bit3), int'(slot3)};
    endcase
    return o;
  endfunction

  task automatic set_en(input int d, input logic v);
    case (d)
      0:       en0 = v;
      1:       en1 = v;
      2:       en2 = v;
      default: en3 = v;
    endcase
  endtask

  task automatic test_reset();
    obs_t o;
    rst_in = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
    repeat (3) @(negedge clk_in);
    for (int d = 0; d < 4; d++) begin
      o = sample(d);
      n_checks++;
      if ({o.sck, o.ws, o.rise, o.fall, o.fs, o.run} !== 6'b0 || o.bidx != 0 || o.sidx != 0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs dut%0d: got sck=%b ws=%b rise=%b fall=%b fs=%b run=%b bit=%0d slot=%0d, expected all 0",
                 d, o.sck, o.ws, o.rise, o.fall, o.fs, o.run, o.bidx, o.sidx);
      end
    end
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);
    for (int d = 0; d < 4; d++) begin
      o = sample(d);
      n_checks++;
      if (o.run !== 1'b0 || o.sck !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL idle_without_enable dut%0d: got run=%b sck=%b, expected run=0 sck=0", d, o.run, o.sck);
      end
    end
  endtask

  task automatic test_fast_clock();
    obs_t o, e;
    int   n, cnt;
    for (int t = 0; t < 40; t++) begin
      n = t / 2;
      e.sck  = ((t % 2) == 1);
      e.rise = ((t % 2) == 1);
      e.fall = ((t % 2) == 0) && (t > 0);
      e.bidx = n % 2;
      e.sidx = (n / 2) % 2;
      e.ws   = (((n + 1) / 2) % 2) == 1;
      e.fs   = (t % 8) == 0;
      e.run  = 1'b1;
      exp_obs_q.push_back(e);
    end
    en3 = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_in);
      o = sample(3);
      e = exp_obs_q.pop_front();
      n_checks++;
      if ({o.sck, o.ws, o.rise, o.fall, o.fs, o.run} !== {e.sck, e.ws, e.rise, e.fall, e.fs, e.run} ||
          o.bidx != e.bidx || o.sidx != e.sidx) begin
        n_fail++;
        $display("[TB] FAIL fast_cycle t=%0d: got sck/ws/rise/fall/fs/run=%b%b%b%b%b%b bit=%0d slot=%0d, expected %b%b%b%b%b%b bit=%0d slot=%0d",
                 t, o.sck, o.ws, o.rise, o.fall, o.fs, o.run, o.bidx, o.sidx,
                 e.sck, e.ws, e.rise, e.fall, e.fs, e.run, e.bidx, e.sidx);
      end
    end
    en3 = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk_in);
      o = sample(3);
      cnt++;
    end while (o.run && cnt < 20);
    n_checks++;
    if (o.run !== 1'b0 || o.sck !== 1'b0 || o.ws !== 1'b0 || o.bidx != 0 || o.sidx != 0) begin
      n_fail++;
      $display("[TB] FAIL fast_drain_idle: got run=%b sck=%b ws=%b bit=%0d slot=%0d after %0d cycles, expected all 0",
               o.run, o.sck, o.ws, o.bidx, o.sidx, cnt);
    end
  endtask

  // Runs DUT d from IDLE for ncycles, matching ws/frame_start events against exp_q.
  task automatic test_frame_timing(input int d, input int ncycles, input int drop_at,
                                   input int raise_at, input int half);
    obs_t o, prev;
    ev_t  e;
    int   nfall, cnt;
    logic hit;
    prev  = sample(d);
    nfall = 0;
    set_en(d, 1'b1);
    for (int t = 0; t < ncycles; t++) begin
      @(negedge clk_in);
      if (t == drop_at) set_en(d, 1'b0);
      if (t == raise_at) set_en(d, 1'b1);
      o = sample(d);
      n_checks++;
      if (o.run !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL running dut%0d t=%0d: got %b, expected 1", d, t, o.run);
      end
      n_checks++;
      if (o.rise !== (o.sck && !prev.sck) || o.fall !== (!o.sck && prev.sck)) begin
        n_fail++;
        $display("[TB] FAIL strobes dut%0d t=%0d: got rise=%b fall=%b, expected rise=%b fall=%b",
                 d, t, o.rise, o.fall, o.sck && !prev.sck, !o.sck && prev.sck);
      end
      if (o.fall) begin
        nfall++;
        n_checks++;
        if (t != nfall * 2 * half) begin
          n_fail++;
          $display("[TB] FAIL fall_time dut%0d fall#%0d: got t=%0d, expected t=%0d", d, nfall, t, nfall * 2 * half);
        end
      end
      for (int k = 0; k < 3; k++) begin
        hit = (k == EV_FS) ? o.fs : (k == EV_WS_RISE) ? (o.ws && !prev.ws) : (!o.ws && prev.ws);
        if (hit) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL event dut%0d: got unexpected kind=%0d at t=%0d, expected none", d, k, t);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != t) begin
              n_fail++;
              $display("[TB] FAIL event dut%0d: got kind=%0d at t=%0d, expected kind=%0d at t=%0d", d, k, t, e.kind, e.cyc);
            end
          end
        end
      end
      prev = o;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_events dut%0d: got %0d left unseen, expected 0", d, exp_q.size());
    end
    exp_q.delete();
    set_en(d, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk_in);
      o = sample(d);
      cnt++;
    end while (o.run && cnt < 5000);
    n_checks++;
    if (o.run !== 1'b0 || o.sck !== 1'b0 || o.ws !== 1'b0 || o.bidx != 0 || o.sidx != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_idle dut%0d: got run=%b sck=%b ws=%b bit=%0d slot=%0d, expected all 0", d, o.run, o.sck, o.ws, o.bidx, o.sidx);
    end
  endtask

  task automatic test_i2s_mode();
    exp_q.push_back('{EV_FS, 0});
    exp_q.push_back('{EV_WS_RISE, 1054});
    exp_q.push_back('{EV_WS_FALL, 2142});
    exp_q.push_back('{EV_FS, 2176});
    exp_q.push_back('{EV_WS_RISE, 3230});
    exp_q.push_back('{EV_WS_FALL, 4318});
    exp_q.push_back('{EV_FS, 4352});
    test_frame_timing(0, 4360, -1, -1, 17);
  endtask

  task automatic test_lj_mode();
    exp_q.push_back('{EV_FS, 0});
    exp_q.push_back('{EV_WS_RISE, 1088});
    exp_q.push_back('{EV_FS, 2176});
    exp_q.push_back('{EV_WS_FALL, 2176});
    test_frame_timing(1, 2200, -1, -1, 17);
  endtask

  task automatic test_tdm_mode();
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back('{EV_FS, 512 * f});
      exp_q.push_back('{EV_WS_RISE, 512 * f});
      exp_q.push_back('{EV_WS_FALL, 512 * f + 4});
    end
    test_frame_timing(2, 1100, -1, -1, 2);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{EV_FS, 0});
    exp_q.push_back('{EV_WS_RISE, 1054});
    exp_q.push_back('{EV_WS_FALL, 2142});
    exp_q.push_back('{EV_FS, 2176});
    test_frame_timing(0, 2200, 200, 400, 17);
  endtask

  task automatic test_drain();
    obs_t o;
    int   t;
    bit   found, saw_last;
    en0   = 1'b1;
    t     = -1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_in);
      t++;
      o = sample(0);
      if (o.sidx == 0 && o.bidx == 10) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL drain_reach_bit10: got bit=%0d slot=%0d at timeout, expected slot 0 bit 10", o.bidx, o.sidx);
    end
    en0 = 1'b0;
    saw_last = 1'b0;
    while (o.run && t < 5000) begin
      @(negedge clk_in);
      t++;
      o = sample(0);
      if (o.run && o.sidx == 1 && o.bidx == 31) saw_last = 1'b1;
    end
    n_checks++;
    if (t < 2176 || t > 2177) begin
      n_fail++;
      $display("[TB] FAIL drain_stop_time: got idle at t=%0d, expected 2176..2177", t);
    end
    n_checks++;
    if (!saw_last) begin
      n_fail++;
      $display("[TB] FAIL drain_full_frame: got last bit seen=%b, expected 1", saw_last);
    end
    n_checks++;
    if (o.run !== 1'b0 || o.sck !== 1'b0 || o.ws !== 1'b0 || o.bidx != 0 || o.sidx != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_outputs: got run=%b sck=%b ws=%b bit=%0d slot=%0d, expected all 0", o.run, o.sck, o.ws, o.bidx, o.sidx);
    end
  endtask

  task automatic test_reset_midframe();
    obs_t o;
    bit   found;
    int   cnt;
    en0   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk_in);
      o = sample(0);
      if (o.sidx == 1 && o.bidx == 5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL reset_reach_slot1: got bit=%0d slot=%0d at timeout, expected slot 1 bit 5", o.bidx, o.sidx);
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    o = sample(0);
    n_checks++;
    if ({o.sck, o.ws, o.rise, o.fall, o.fs, o.run} !== 6'b0 || o.bidx != 0 || o.sidx != 0) begin
      n_fail++;
      $display("[TB] FAIL midframe_reset: got sck=%b ws=%b rise=%b fall=%b fs=%b run=%b bit=%0d slot=%0d, expected all 0",
               o.sck, o.ws, o.rise, o.fall, o.fs, o.run, o.bidx, o.sidx);
    end
    rst_in = 1'b0;
    @(negedge clk_in);
    o = sample(0);
    n_checks++;
    if (o.run !== 1'b1 || o.fs !== 1'b1 || o.bidx != 0 || o.sidx != 0) begin
      n_fail++;
      $display("[TB] FAIL restart_after_reset: got run=%b fs=%b bit=%0d slot=%0d, expected run=1 fs=1 bit=0 slot=0",
               o.run, o.fs, o.bidx, o.sidx);
    end
    en0 = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk_in);
      o = sample(0);
      cnt++;
    end while (o.run && cnt < 5000);
    n_checks++;
    if (o.run !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL final_idle: got run=%b, expected 0", o.run);
    end
  endtask

  initial begin
    test_reset();
    test_fast_clock();
    test_i2s_mode();
    test_lj_mode();
    test_tdm_mode();
    test_drain();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
